// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        BLINK   = 2'd1,
        CHASE   = 2'd2,
        BREATHE = 2'd3
    } mode_e;

    localparam int unsigned TICK_HZ           = 1000;
    localparam logic [15:0] DEFAULT_PERIOD_MS = 16'd500;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by DIV into a registered one-cycle tick; clr restarts the count.
// Latency: first tick DIV cycles after reset/clr release; no backpressure.
module tick_prescaler #(
    parameter int unsigned DIV = 27000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Active-low LED pattern generator (off/blink/chase/breathe) stepped every cfg period in ms.
// Latency: new pattern visible the edge after acceptance; cfg_ready drops for one cycle per accept.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned CLOCK_XTAL = 27000000,
    parameter int          LED_NUM    = 6,
    parameter int          DUTY_BITS  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mode,
    input  logic [15:0]        cfg_period_ms,
    output logic               step_o,
    output logic [LED_NUM-1:0] leds
);

    localparam int unsigned DIV = CLOCK_XTAL / TICK_HZ;
    localparam logic [DUTY_BITS-1:0] DUTY_MAX = '1;

    if (DIV < 2 || LED_NUM < 1 || LED_NUM > 32) begin : g_bad_params
        $error("led_pattern_gen: DIV must be >= 2 and LED_NUM within 1..32");
    end

    mode_e                mode_q, mode_d;
    logic [15:0]          period_q, period_d;
    logic [15:0]          step_cnt_q, step_cnt_d;
    logic [LED_NUM-1:0]   pat_q, pat_d;
    logic [DUTY_BITS-1:0] pwm_q, pwm_d;
    logic [DUTY_BITS-1:0] duty_q, duty_d;
    logic                 dir_up_q, dir_up_d;
    logic                 ready_q, ready_d;

    logic        tick;
    logic        accept;
    logic [15:0] period_eff;
    logic        step_last;

    assign accept     = cfg_valid && ready_q;
    assign period_eff = (period_q == 16'd0) ? 16'd1 : period_q;
    assign step_last  = (step_cnt_q == period_eff - 16'd1);
    // A reconfiguration in the same cycle swallows the pending step.
    assign step_o     = tick && step_last && !accept;

    tick_prescaler #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    always_comb begin
        mode_d     = mode_q;
        period_d   = period_q;
        step_cnt_d = step_cnt_q;
        pat_d      = pat_q;
        duty_d     = duty_q;
        dir_up_d   = dir_up_q;
        pwm_d      = pwm_q + 1'b1;
        ready_d    = !accept;
        if (accept) begin
            mode_d     = mode_e'(cfg_mode);
            period_d   = cfg_period_ms;
            step_cnt_d = '0;
            duty_d     = '0;
            dir_up_d   = 1'b1;
            pat_d      = '0;
            if (mode_d == CHASE) pat_d[0] = 1'b1;
        end else begin
            if (tick) step_cnt_d = step_last ? 16'd0 : step_cnt_q + 16'd1;
            if (step_o) begin
                case (mode_q)
                    BLINK:   pat_d = ~pat_q;
                    CHASE:   pat_d = (pat_q << 1) | (pat_q >> (LED_NUM - 1));
                    BREATHE: begin
                        if (dir_up_q) begin
                            if (duty_q == DUTY_MAX) begin
                                dir_up_d = 1'b0;
                                duty_d   = DUTY_MAX - 1'b1;
                            end else begin
                                duty_d = duty_q + 1'b1;
                            end
                        end else if (duty_q == '0) begin
                            dir_up_d = 1'b1;
                            duty_d   = DUTY_BITS'(1);
                        end else begin
                            duty_d = duty_q - 1'b1;
                        end
                    end
                    default: pat_d = '0;
                endcase
            end
        end
        // Pattern tracks next-cycle pwm/duty so the register matches pwm_q < duty_q exactly.
        if (mode_d == BREATHE) pat_d = {LED_NUM{pwm_d < duty_d}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= OFF;
            period_q   <= DEFAULT_PERIOD_MS;
            step_cnt_q <= '0;
            pat_q      <= '0;
            pwm_q      <= '0;
            duty_q     <= '0;
            dir_up_q   <= 1'b1;
            ready_q    <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            period_q   <= period_d;
            step_cnt_q <= step_cnt_d;
            pat_q      <= pat_d;
            pwm_q      <= pwm_d;
            duty_q     <= duty_d;
            dir_up_q   <= dir_up_d;
            ready_q    <= ready_d;
        end
    end

    assign cfg_ready = ready_q;
    assign leds      = ~pat_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: expected step events are queued at configuration time and popped by a step_o monitor.
module tb_led_pattern_gen;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_period_ms;
    logic        step_o;
    logic [5:0]  leds;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [5:0] leds;
        bit         chk_leds;
    } exp_t;

    exp_t exp_q[$];

    led_pattern_gen #(
        .CLOCK_XTAL (4000),
        .LED_NUM    (6),
        .DUTY_BITS  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_mode      (cfg_mode),
        .cfg_period_ms (cfg_period_ms),
        .step_o        (step_o),
        .leds          (leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int c, input logic [5:0] l, input bit chk);
        exp_t e;
        e.cyc      = c;
        e.leds     = l;
        e.chk_leds = chk;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed step_o must match the next queued expectation.
    always @(negedge clk) begin
        if (step_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_step: step_o=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("step_cycle", cyc, e.cyc);
                if (e.chk_leds) check("step_leds", int'(leds), int'(e.leds));
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a clk edge; returns the cycle index of the accepting edge.
    task automatic do_cfg(input logic [1:0] m, input logic [15:0] p,
                          input logic [5:0] init_leds, output int acc);
        cfg_valid     = 1'b1;
        cfg_mode      = m;
        cfg_period_ms = p;
        #1;
        check("ready_before_accept", int'(cfg_ready), 1);
        check("no_step_on_accept", int'(step_o), 0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        acc = cyc;
        check("ready_low_after_accept", int'(cfg_ready), 0);
        check("init_pattern", int'(leds), int'(init_leds));
        @(posedge clk);
        #1;
        check("ready_restored", int'(cfg_ready), 1);
    endtask

    initial begin
        int a;
        int b;
        int r;
        int lit[8];
        int bad;
        int exp_duty[8];
        exp_duty = '{0, 1, 2, 3, 2, 1, 0, 1};

        rst           = 1'b1;
        cfg_valid     = 1'b0;
        cfg_mode      = 2'd0;
        cfg_period_ms = 16'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("reset_leds", int'(leds), 'h3f);
        check("reset_ready", int'(cfg_ready), 1);
        check("reset_step", int'(step_o), 0);
        rst = 1'b0;

        // BLINK, period 2: a step every 8 cycles, first step shows all-off.
        do_cfg(2'd1, 16'd2, 6'b111111, a);
        push(a + 8,  6'b111111, 1);
        push(a + 16, 6'b000000, 1);
        push(a + 24, 6'b111111, 1);
        push(a + 32, 6'b000000, 1);
        wait_until(a + 34);

        // CHASE, period 1: one-hot walks left and wraps.
        do_cfg(2'd2, 16'd1, 6'b111110, a);
        push(a + 4,  6'b111110, 1);
        push(a + 8,  6'b111101, 1);
        push(a + 12, 6'b111011, 1);
        push(a + 16, 6'b110111, 1);
        push(a + 20, 6'b101111, 1);
        push(a + 24, 6'b011111, 1);
        push(a + 28, 6'b111110, 1);
        wait_until(a + 29);

        // BREATHE, period 1, 2-bit duty: lit cycles per 4-cycle window follow the duty.
        do_cfg(2'd3, 16'd1, 6'b111111, a);
        for (int k = 1; k <= 7; k++) push(a + 4 * k, 6'b000000, 0);
        for (int k = 0; k < 8; k++) lit[k] = 0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (leds == 6'b000000) lit[i / 4]++;
            else if (leds != 6'b111111) bad++;
            if (i < 31) begin
                @(posedge clk);
                #1;
            end
        end
        check("breathe_uniform", bad, 0);
        for (int k = 0; k < 8; k++) check($sformatf("breathe_duty%0d", k), lit[k], exp_duty[k]);

        // Collision: the step at a+32 above and at a2+12 below are swallowed by acceptance.
        do_cfg(2'd1, 16'd1, 6'b111111, a);
        push(a + 4, 6'b111111, 1);
        push(a + 8, 6'b000000, 1);
        wait_until(a + 12);
        do_cfg(2'd2, 16'd1, 6'b111110, b);
        check("collision_restart", b, a + 13);
        push(b + 4, 6'b111110, 1);
        push(b + 8, 6'b111101, 1);
        wait_until(b + 10);

        // Asynchronous reset mid-CHASE takes effect before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_leds", int'(leds), 'h3f);
        check("async_rst_ready", int'(cfg_ready), 1);
        check("async_rst_step", int'(step_o), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        r = cyc;
        push(r + 2000, 6'b111111, 1);
        wait_until(r + 2001);

        // Period 0 behaves as period 1.
        do_cfg(2'd1, 16'd0, 6'b111111, a);
        push(a + 4,  6'b111111, 1);
        push(a + 8,  6'b000000, 1);
        push(a + 12, 6'b111111, 1);
        wait_until(a + 13);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
